// File: rtl/reg_alu_ctrl_pkg.sv
// Shared definitions for the reg_alu command sequencer: command kinds, ALU op codes,
// FSM state encoding and the helper that resolves a conditional ALU command.
package reg_alu_ctrl_pkg;

    typedef enum logic [1:0] {
        KindLdi  = 2'b00,
        KindAlu  = 2'b01,
        KindClrf = 2'b10,
        KindAluc = 2'b11
    } cmd_kind_e;

    // ALU ops are passed through opaquely; only add has a fixed code.
    localparam logic [1:0] OpAdd = 2'b00;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } state_e;

    // A conditional ALU command runs as a plain ALU command when enabled and the
    // carry flag is set; otherwise it stays KindAluc and executes as a NOP.
    function automatic cmd_kind_e resolve_kind(input cmd_kind_e kind,
                                               input logic      cond_en,
                                               input logic      flag);
        if (kind == KindAluc && cond_en && flag) begin
            return KindAlu;
        end
        return kind;
    endfunction

endpackage

// File: rtl/reg_alu_ctrl_if.sv
// Command handshake bundle between a host and reg_alu_ctrl.
// master = command source, slave = the sequencer.
interface reg_alu_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CNT_W  = 4
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_kind;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_ra;
    logic [ADDR_W-1:0] cmd_rb;
    logic [DATA_W-1:0] cmd_imm;
    logic [CNT_W-1:0]  cmd_cnt;

    modport master (
        output cmd_valid, cmd_kind, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, cmd_cnt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, cmd_cnt,
        output cmd_ready
    );

endinterface

// File: rtl/reg_alu_ctrl.sv
// Command sequencer for the 8x16 register-file/ALU datapath.
// One command per valid/ready handshake; FSM Idle -> Exec (1..2^CNT_W cycles) -> Done.
// Optional feature: define REG_ALU_CTRL_COND_EN to make ALUC execute as ALU when the
// carry flag was set at accept; otherwise ALUC is a single-cycle NOP.
module reg_alu_ctrl
    import reg_alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    reg_alu_ctrl_if.slave     cmd,
    input  logic              alu_cout,
    output logic              rf_sel,
    output logic              rf_wr,
    output logic [1:0]        rf_op,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_d_in,
    output logic              busy,
    output logic              done,
    output logic              carry_flag
);

`ifdef REG_ALU_CTRL_COND_EN
    localparam logic CondEn = 1'b1;
`else
    localparam logic CondEn = 1'b0;
`endif

    state_e            state_q, state_d;
    cmd_kind_e         kind_q, kind_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [ADDR_W-1:0] rb_q, rb_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CNT_W-1:0]  iter_q, iter_d;
    logic              first_q, first_d;
    logic              carry_q, carry_d;

    logic accept;
    logic in_exec;

    assign accept  = cmd.cmd_valid & (state_q == StIdle) & ~reset;
    assign in_exec = (state_q == StExec);

    // State and command registers; synchronous reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            kind_q  <= KindLdi;
            op_q    <= '0;
            rd_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            imm_q   <= '0;
            iter_q  <= '0;
            first_q <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            imm_q   <= imm_d;
            iter_q  <= iter_d;
            first_q <= first_d;
            carry_q <= carry_d;
        end
    end

    // Next-state logic for the command FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  if (iter_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command latch, iteration counter and sticky carry update.
    always_comb begin
        kind_d  = kind_q;
        op_d    = op_q;
        rd_d    = rd_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        imm_d   = imm_q;
        iter_d  = iter_q;
        first_d = first_q;
        carry_d = carry_q;

        if (accept) begin
            // ALUC is resolved against the flag as it stands at accept.
            kind_d  = resolve_kind(cmd_kind_e'(cmd.cmd_kind), CondEn, carry_q);
            op_d    = cmd.cmd_op;
            rd_d    = cmd.cmd_rd;
            ra_d    = cmd.cmd_ra;
            rb_d    = cmd.cmd_rb;
            imm_d   = cmd.cmd_imm;
            iter_d  = (kind_d == KindAlu) ? cmd.cmd_cnt : '0;
            first_d = 1'b1;
        end

        if (in_exec) begin
            if (iter_q != '0) begin
                iter_d  = iter_q - CNT_W'(1);
                first_d = 1'b0;
            end
            unique case (kind_q)
                KindAlu:  carry_d = alu_cout;
                KindClrf: carry_d = 1'b0;
                default:  carry_d = carry_q;
            endcase
        end
    end

    // Outputs decoded from state and the latched command.
    always_comb begin
        cmd.cmd_ready = (state_q == StIdle);
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
        carry_flag    = carry_q;
        rf_sel        = in_exec & (kind_q == KindAlu);
        // Write gating by reset is combinational so a reset cycle never writes.
        rf_wr         = in_exec & ((kind_q == KindAlu) | (kind_q == KindLdi)) & ~reset;
        rf_op         = op_q;
        rf_wr_addr    = rd_q;
        rf_rd_addr_b  = rb_q;
        // Later iterations read the destination back: rd = rd op rb.
        rf_rd_addr_a  = (in_exec & ~first_q) ? rd_q : ra_q;
        rf_d_in       = imm_q;
    end

endmodule
